// File: rtl/matvec_pkg.sv
// Shared types and default sizing for the matrix-vector MAC sequencer.
package matvec_pkg;

    // Encodings are fixed so the state can be read directly on debug buses.
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        CLEAR = 3'd2,
        EXEC  = 3'd3,
        DRAIN = 3'd4,
        OUT   = 3'd5,
        DONE  = 3'd6
    } seq_state_t;

    localparam int N_DEF     = 8;
    localparam int K_DEF     = 8;
    localparam int ACC_W_DEF = 24;
    localparam int BATCH_DEF = 1;

endpackage

// File: rtl/matvec_lane_pop.sv
// Skewed A-FIFO pop generation, B-FIFO pop gating and sticky underflow flag.
// A pop requested against an empty FIFO is dropped and latches err; the
// sequence itself is never stalled by an underflow.
module matvec_lane_pop
    import matvec_pkg::*;
#(
    parameter int N = N_DEF
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         pop_phase,
    input  logic         mac_en,
    input  logic [N-1:0] mac_en_out,
    input  logic [N-1:0] a_empty,
    input  logic         b_req,
    input  logic         b_empty,
    output logic [N-1:0] a_rden,
    output logic         b_rden,
    output logic         err
);

    logic [N-1:0] a_req;
    logic         err_q;
    logic         err_d;
    logic         unused_en_last;

    // The last stage enable leaves the array and has no lane to feed.
    assign unused_en_last = mac_en_out[N-1];

    // Lane i pops in step with the enable arriving at MAC stage i.
    always_comb begin
        a_req = '0;
        if (pop_phase) begin
            a_req = {mac_en_out[N-2:0], mac_en};
        end
    end

    // Suppress pops against empty FIFOs and accumulate the underflow flag.
    always_comb begin
        a_rden = a_req & ~a_empty;
        b_rden = b_req & ~b_empty;
        err_d  = err_q | (|(a_req & a_empty)) | (b_req & b_empty);
    end

    // Sticky error register, cleared only by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err = err_q;

endmodule

// File: rtl/matvec_seq.sv
// Matrix-vector MAC sequencer: load -> clear -> exec -> drain -> result
// stream, repeated BATCH times per start.
// Optional busy-cycle counter enabled by defining MATVEC_SEQ_PERF_EN;
// without it perf_cycles is tied to zero.
//
// state | meaning
// IDLE  | waiting for start
// LOAD  | load_req held until fetch controller signals load_done
// CLEAR | clear MAC accumulators, prefetch first B entry
// EXEC  | K cycles of mac_en, B popped on all but the last
// DRAIN | N cycles letting the skewed pipeline finish its A pops
// OUT   | stream one accumulator per lane on res_*
// DONE  | single-cycle done pulse
module matvec_seq
    import matvec_pkg::*;
#(
    parameter int N     = N_DEF,
    parameter int K     = K_DEF,
    parameter int ACC_W = ACC_W_DEF,
    parameter int BATCH = BATCH_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    output logic                 busy,
    output logic                 done,
    output logic                 load_req,
    input  logic                 load_done,
    input  logic [N-1:0]         a_empty,
    output logic [N-1:0]         a_rden,
    input  logic                 b_empty,
    output logic                 b_rden,
    output logic                 mac_clr,
    output logic                 mac_en,
    input  logic [N-1:0]         mac_en_out,
    input  logic [N*ACC_W-1:0]   mac_c,
    output logic                 res_valid,
    input  logic                 res_ready,
    output logic [ACC_W-1:0]     res_data,
    output logic [$clog2(N)-1:0] res_lane,
    output logic                 res_last,
    output logic                 err,
    output logic [31:0]          perf_cycles
);

    localparam int KW = $clog2(K + 1);
    localparam int DW = $clog2(N + 1);
    localparam int LW = $clog2(N);
    localparam int BW = $clog2(BATCH + 1);

    localparam logic [KW-1:0] K_LAST = KW'(K - 1);
    localparam logic [DW-1:0] D_INIT = DW'(N);
    localparam logic [DW-1:0] D_ONE  = DW'(1);
    localparam logic [LW-1:0] L_LAST = LW'(N - 1);
    localparam logic [BW-1:0] B_LAST = BW'(BATCH - 1);

    seq_state_t    state_q, state_d;
    logic [BW-1:0] batch_q, batch_d;
    logic [KW-1:0] k_q, k_d;
    logic [DW-1:0] drain_q, drain_d;
    logic [LW-1:0] lane_q, lane_d;
    logic          b_req;
    logic          pop_phase;

    // State and counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            batch_q <= '0;
            k_q     <= '0;
            drain_q <= '0;
            lane_q  <= '0;
        end else begin
            state_q <= state_d;
            batch_q <= batch_d;
            k_q     <= k_d;
            drain_q <= drain_d;
            lane_q  <= lane_d;
        end
    end

    // Next-state, counter updates and per-state control strobes.
    always_comb begin
        state_d   = state_q;
        batch_d   = batch_q;
        k_d       = k_q;
        drain_d   = drain_q;
        lane_d    = lane_q;
        load_req  = 1'b0;
        mac_clr   = 1'b0;
        mac_en    = 1'b0;
        b_req     = 1'b0;
        res_valid = 1'b0;
        done      = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = LOAD;
                    batch_d = '0;
                end
            end
            LOAD: begin
                load_req = 1'b1;
                if (load_done) begin
                    state_d = CLEAR;
                end
            end
            CLEAR: begin
                mac_clr = 1'b1;
                b_req   = 1'b1;
                k_d     = '0;
                state_d = EXEC;
            end
            EXEC: begin
                mac_en = 1'b1;
                if (k_q == K_LAST) begin
                    drain_d = D_INIT;
                    state_d = DRAIN;
                end else begin
                    b_req = 1'b1;
                    k_d   = k_q + KW'(1);
                end
            end
            DRAIN: begin
                drain_d = drain_q - DW'(1);
                if (drain_q == D_ONE) begin
                    lane_d  = '0;
                    state_d = OUT;
                end
            end
            OUT: begin
                res_valid = 1'b1;
                if (res_ready) begin
                    if (lane_q == L_LAST) begin
                        if (batch_q < B_LAST) begin
                            batch_d = batch_q + BW'(1);
                            state_d = LOAD;
                        end else begin
                            state_d = DONE;
                        end
                    end else begin
                        lane_d = lane_q + LW'(1);
                    end
                end
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Result lane mux; outputs held at zero outside OUT.
    always_comb begin
        res_data = '0;
        res_lane = '0;
        res_last = 1'b0;
        if (state_q == OUT) begin
            res_lane = lane_q;
            res_last = (lane_q == L_LAST);
            for (int i = 0; i < N; i++) begin
                if (lane_q == LW'(i)) begin
                    res_data = mac_c[i*ACC_W +: ACC_W];
                end
            end
        end
    end

    assign busy      = (state_q != IDLE);
    assign pop_phase = (state_q == EXEC) || (state_q == DRAIN);

    matvec_lane_pop #(.N(N)) u_lane_pop (
        .clk        (clk),
        .rst        (rst),
        .pop_phase  (pop_phase),
        .mac_en     (mac_en),
        .mac_en_out (mac_en_out),
        .a_empty    (a_empty),
        .b_req      (b_req),
        .b_empty    (b_empty),
        .a_rden     (a_rden),
        .b_rden     (b_rden),
        .err        (err)
    );

`ifdef MATVEC_SEQ_PERF_EN
    logic [31:0] perf_q, perf_d;

    // Busy-cycle count: restarts on an accepted start, saturates at all-ones.
    always_comb begin
        perf_d = perf_q;
        if ((state_q == IDLE) && start) begin
            perf_d = '0;
        end else if (busy && (perf_q != 32'hFFFF_FFFF)) begin
            perf_d = perf_q + 32'd1;
        end
    end

    // Performance counter register.
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_q <= '0;
        end else begin
            perf_q <= perf_d;
        end
    end

    assign perf_cycles = perf_q;
`else
    assign perf_cycles = '0;
`endif

endmodule

// File: tb/tb_matvec_seq.sv
// Directed bench for matvec_seq. Two DUTs share clock and reset:
// unit 0 with BATCH=1, unit 1 with BATCH=3. Each has a behavioural
// FIFO + skewed MAC array model around it.
module tb_matvec_seq;

    localparam int N     = 8;
    localparam int K     = 8;
    localparam int ACC_W = 24;
    localparam int LW    = 3;

    logic clk = 1'b0;
    logic rst;

    logic [1:0]            start, load_done, res_ready;
    logic [1:0]            busy, done, load_req, b_rden, mac_clr, mac_en;
    logic [1:0]            res_valid, res_last, err;
    logic [1:0][N-1:0]     a_rden;
    logic [1:0][ACC_W-1:0] res_data;
    logic [1:0][LW-1:0]    res_lane;
    logic [1:0][31:0]      perf_cycles;

    logic [7:0] a_val   [2][N];
    logic [3:0] a_depth [2][N];
    logic [7:0] b_val   [2][K];
    logic [3:0] b_depth [2];

    int checks = 0;
    int errors = 0;

    int   lreq_rises  = 0;
    int   done_pulses = 0;
    logic lreq_prev   = 1'b0;

    always #5 clk = ~clk;

    for (genvar u = 0; u < 2; u++) begin : g_u
        logic [N-1:0]       en_pipe = '0;
        logic [N-1:0]       a_empty;
        logic               b_empty;
        logic [3:0]         a_pops [N];
        logic [3:0]         b_pops;
        logic [ACC_W-1:0]   acc [N];
        logic [N*ACC_W-1:0] mac_c;

        always_comb begin
            a_empty = '0;
            mac_c   = '0;
            for (int i = 0; i < N; i++) begin
                a_empty[i]               = (a_pops[i] >= a_depth[u][i]);
                mac_c[i*ACC_W +: ACC_W]  = acc[i];
            end
            b_empty = (b_pops >= b_depth[u]);
        end

        always_ff @(posedge clk) begin
            en_pipe <= {en_pipe[N-2:0], mac_en[u]};
            if (rst || load_done[u]) begin
                for (int i = 0; i < N; i++) a_pops[i] <= '0;
                b_pops <= '0;
            end else begin
                for (int i = 0; i < N; i++) begin
                    if (a_rden[u][i]) a_pops[i] <= a_pops[i] + 4'd1;
                end
                if (b_rden[u]) b_pops <= b_pops + 4'd1;
            end
            for (int i = 0; i < N; i++) begin
                if (mac_clr[u]) begin
                    acc[i] <= '0;
                end else if (a_rden[u][i]) begin
                    acc[i] <= acc[i] + ACC_W'(a_val[u][i]) * ACC_W'(b_val[u][a_pops[i][2:0]]);
                end
            end
        end

        matvec_seq #(.N(N), .K(K), .ACC_W(ACC_W), .BATCH(u == 0 ? 1 : 3)) dut (
            .clk         (clk),
            .rst         (rst),
            .start       (start[u]),
            .busy        (busy[u]),
            .done        (done[u]),
            .load_req    (load_req[u]),
            .load_done   (load_done[u]),
            .a_empty     (a_empty),
            .a_rden      (a_rden[u]),
            .b_empty     (b_empty),
            .b_rden      (b_rden[u]),
            .mac_clr     (mac_clr[u]),
            .mac_en      (mac_en[u]),
            .mac_en_out  (en_pipe),
            .mac_c       (mac_c),
            .res_valid   (res_valid[u]),
            .res_ready   (res_ready[u]),
            .res_data    (res_data[u]),
            .res_lane    (res_lane[u]),
            .res_last    (res_last[u]),
            .err         (err[u]),
            .perf_cycles (perf_cycles[u])
        );
    end

    always @(posedge clk) begin
        lreq_prev <= load_req[1];
        if (load_req[1] && !lreq_prev) lreq_rises <= lreq_rises + 1;
        if (done[1]) done_pulses <= done_pulses + 1;
    end

    task automatic prep(input int u, input int bmode, input int lane3_depth);
        for (int i = 0; i < N; i++) begin
            a_val[u][i]   = 8'(i + 1);
            a_depth[u][i] = 4'(K);
        end
        a_depth[u][3] = 4'(lane3_depth);
        for (int j = 0; j < K; j++) begin
            b_val[u][j] = (bmode == 0) ? 8'd2 : (bmode == 1) ? 8'(j) : 8'd0;
        end
        b_depth[u] = 4'(K);
    endtask

    task automatic pulse_start(input int u);
        start[u] = 1'b1;
        @(negedge clk);
        start[u] = 1'b0;
    endtask

    // load_done arrives in the lat-th cycle of LOAD.
    task automatic do_load(input int u, input int lat);
        int t = 0;
        while (load_req[u] !== 1'b1 && t < 300) begin
            @(negedge clk);
            t++;
        end
        checks++;
        if (t >= 300) begin
            errors++;
            $display("FAIL load_req_wait u=%0d got 0 expected 1", u);
        end
        repeat (lat - 1) @(negedge clk);
        load_done[u] = 1'b1;
        @(negedge clk);
        load_done[u] = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        for (int u = 0; u < 2; u++) begin
            checks++; if (busy[u] !== 1'b0)      begin errors++; $display("FAIL rst_busy u=%0d got %b expected 0", u, busy[u]); end
            checks++; if (done[u] !== 1'b0)      begin errors++; $display("FAIL rst_done u=%0d got %b expected 0", u, done[u]); end
            checks++; if (load_req[u] !== 1'b0)  begin errors++; $display("FAIL rst_load_req u=%0d got %b expected 0", u, load_req[u]); end
            checks++; if (a_rden[u] !== '0)      begin errors++; $display("FAIL rst_a_rden u=%0d got %h expected 0", u, a_rden[u]); end
            checks++; if (b_rden[u] !== 1'b0)    begin errors++; $display("FAIL rst_b_rden u=%0d got %b expected 0", u, b_rden[u]); end
            checks++; if (mac_clr[u] !== 1'b0)   begin errors++; $display("FAIL rst_mac_clr u=%0d got %b expected 0", u, mac_clr[u]); end
            checks++; if (mac_en[u] !== 1'b0)    begin errors++; $display("FAIL rst_mac_en u=%0d got %b expected 0", u, mac_en[u]); end
            checks++; if (res_valid[u] !== 1'b0) begin errors++; $display("FAIL rst_res_valid u=%0d got %b expected 0", u, res_valid[u]); end
            checks++; if (res_data[u] !== '0)    begin errors++; $display("FAIL rst_res_data u=%0d got %0d expected 0", u, res_data[u]); end
            checks++; if (res_last[u] !== 1'b0)  begin errors++; $display("FAIL rst_res_last u=%0d got %b expected 0", u, res_last[u]); end
            checks++; if (err[u] !== 1'b0)       begin errors++; $display("FAIL rst_err u=%0d got %b expected 0", u, err[u]); end
            checks++; if (perf_cycles[u] !== '0) begin errors++; $display("FAIL rst_perf u=%0d got %0d expected 0", u, perf_cycles[u]); end
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic();
        int t = 0;
        logic [ACC_W-1:0] exp_d;
        prep(0, 0, 8);
        pulse_start(0);
        do_load(0, 20);
        checks++; if (mac_clr[0] !== 1'b1 || b_rden[0] !== 1'b1) begin errors++; $display("FAIL basic_clear mac_clr=%b b_rden=%b expected 1 1", mac_clr[0], b_rden[0]); end
        while (res_valid[0] !== 1'b1 && t < 100) begin @(negedge clk); t++; end
        checks++; if (t >= 100) begin errors++; $display("FAIL basic_valid_wait got 0 expected 1"); end
        for (int i = 0; i < N; i++) begin
            exp_d = ACC_W'((i + 1) * 16);
            checks++; if (res_lane[0] !== LW'(i)) begin errors++; $display("FAIL basic_lane got %0d expected %0d", res_lane[0], i); end
            checks++; if (res_data[0] !== exp_d)  begin errors++; $display("FAIL basic_data lane %0d got %0d expected %0d", i, res_data[0], exp_d); end
            checks++; if (res_last[0] !== (i == N - 1)) begin errors++; $display("FAIL basic_last lane %0d got %b", i, res_last[0]); end
            checks++; if (done[0] !== 1'b0) begin errors++; $display("FAIL basic_early_done lane %0d got 1 expected 0", i); end
            @(negedge clk);
        end
        checks++; if (done[0] !== 1'b1) begin errors++; $display("FAIL basic_done got %b expected 1", done[0]); end
        start[0] = 1'b1;
        @(negedge clk);
        start[0] = 1'b0;
        checks++; if (busy[0] !== 1'b0 || done[0] !== 1'b0) begin errors++; $display("FAIL done_start_ignored busy=%b done=%b expected 0 0", busy[0], done[0]); end
        checks++; if (err[0] !== 1'b0) begin errors++; $display("FAIL basic_err got %b expected 0", err[0]); end
        @(negedge clk);
    endtask

    task automatic test_backpressure();
        int t = 0;
        int exp_i = 0;
        int c = 0;
        logic [ACC_W-1:0] exp_d;
        prep(0, 0, 8);
        pulse_start(0);
        do_load(0, 3);
        while (res_valid[0] !== 1'b1 && t < 100) begin @(negedge clk); t++; end
        checks++; if (t >= 100) begin errors++; $display("FAIL bp_valid_wait got 0 expected 1"); end
        while (exp_i < N && c < 64) begin
            res_ready[0] = ((c % 4) == 0) || ((c % 4) == 3);
            exp_d = ACC_W'((exp_i + 1) * 16);
            checks++;
            if (res_valid[0] !== 1'b1 || res_lane[0] !== LW'(exp_i) || res_data[0] !== exp_d) begin
                errors++;
                $display("FAIL bp_hold cyc %0d valid=%b lane=%0d data=%0d expected 1 %0d %0d", c, res_valid[0], res_lane[0], res_data[0], exp_i, exp_d);
            end
            if (res_ready[0]) exp_i++;
            c++;
            @(negedge clk);
        end
        res_ready[0] = 1'b1;
        checks++; if (exp_i != N) begin errors++; $display("FAIL bp_count got %0d expected %0d", exp_i, N); end
        checks++; if (done[0] !== 1'b1) begin errors++; $display("FAIL bp_done got %b expected 1", done[0]); end
        @(negedge clk);
    endtask

    task automatic test_batch();
        int t;
        int bsum;
        logic [ACC_W-1:0] exp_d;
        prep(1, 0, 8);
        pulse_start(1);
        for (int b = 0; b < 3; b++) begin
            prep(1, b, 8);
            bsum = (b == 0) ? 16 : (b == 1) ? 28 : 0;
            do_load(1, 3);
            t = 0;
            while (res_valid[1] !== 1'b1 && t < 100) begin @(negedge clk); t++; end
            checks++; if (t >= 100) begin errors++; $display("FAIL batch_valid_wait batch %0d got 0 expected 1", b); end
            for (int i = 0; i < N; i++) begin
                exp_d = ACC_W'((i + 1) * bsum);
                checks++;
                if (res_lane[1] !== LW'(i) || res_data[1] !== exp_d || res_last[1] !== (i == N - 1)) begin
                    errors++;
                    $display("FAIL batch_data batch %0d lane=%0d data=%0d last=%b expected %0d %0d", b, res_lane[1], res_data[1], res_last[1], i, exp_d);
                end
                @(negedge clk);
            end
        end
        checks++; if (done[1] !== 1'b1) begin errors++; $display("FAIL batch_done got %b expected 1", done[1]); end
        @(negedge clk);
        checks++; if (lreq_rises != 3) begin errors++; $display("FAIL batch_load_req_count got %0d expected 3", lreq_rises); end
        checks++; if (done_pulses != 1) begin errors++; $display("FAIL batch_done_count got %0d expected 1", done_pulses); end
        checks++; if (busy[1] !== 1'b0) begin errors++; $display("FAIL batch_idle got %b expected 0", busy[1]); end
    endtask

    task automatic test_underflow();
        int t = 0;
        logic [ACC_W-1:0] exp_d;
        prep(0, 0, 7);
        pulse_start(0);
        do_load(0, 3);
        while (err[0] !== 1'b1 && t < 60) begin @(negedge clk); t++; end
        checks++; if (t >= 60) begin errors++; $display("FAIL uf_err_wait got 0 expected 1"); end
        checks++;
        if (busy[0] !== 1'b1 || mac_en[0] !== 1'b0 || res_valid[0] !== 1'b0 || mac_clr[0] !== 1'b0 || load_req[0] !== 1'b0) begin
            errors++;
            $display("FAIL uf_in_drain busy=%b mac_en=%b valid=%b expected 1 0 0", busy[0], mac_en[0], res_valid[0]);
        end
        t = 0;
        while (res_valid[0] !== 1'b1 && t < 100) begin @(negedge clk); t++; end
        checks++; if (t >= 100) begin errors++; $display("FAIL uf_valid_wait got 0 expected 1"); end
        for (int i = 0; i < N; i++) begin
            exp_d = (i == 3) ? ACC_W'(56) : ACC_W'((i + 1) * 16);
            checks++;
            if (res_lane[0] !== LW'(i) || res_data[0] !== exp_d) begin
                errors++;
                $display("FAIL uf_data lane=%0d data=%0d expected %0d %0d", res_lane[0], res_data[0], i, exp_d);
            end
            @(negedge clk);
        end
        checks++; if (done[0] !== 1'b1) begin errors++; $display("FAIL uf_done got %b expected 1", done[0]); end
        repeat (3) @(negedge clk);
        checks++; if (err[0] !== 1'b1) begin errors++; $display("FAIL uf_err_sticky got %b expected 1", err[0]); end
    endtask

    task automatic test_reset_mid_exec();
        int t = 0;
        logic [ACC_W-1:0] exp_d;
        prep(0, 0, 8);
        pulse_start(0);
        do_load(0, 3);
        repeat (2) @(negedge clk);
        checks++; if (mac_en[0] !== 1'b1) begin errors++; $display("FAIL mid_in_exec got %b expected 1", mac_en[0]); end
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (busy[0] !== 1'b0 || a_rden[0] !== '0 || b_rden[0] !== 1'b0 || res_valid[0] !== 1'b0 || mac_en[0] !== 1'b0) begin
            errors++;
            $display("FAIL mid_rst busy=%b a_rden=%h b_rden=%b valid=%b expected all 0", busy[0], a_rden[0], b_rden[0], res_valid[0]);
        end
        checks++; if (err[0] !== 1'b0) begin errors++; $display("FAIL mid_rst_err got %b expected 0", err[0]); end
        rst = 1'b0;
        @(negedge clk);
        checks++; if (a_rden[0] !== '0) begin errors++; $display("FAIL mid_idle_pop got %h expected 0", a_rden[0]); end
        pulse_start(0);
        do_load(0, 4);
        while (res_valid[0] !== 1'b1 && t < 100) begin @(negedge clk); t++; end
        checks++; if (t >= 100) begin errors++; $display("FAIL mid_valid_wait got 0 expected 1"); end
        for (int i = 0; i < N; i++) begin
            exp_d = ACC_W'((i + 1) * 16);
            checks++;
            if (res_lane[0] !== LW'(i) || res_data[0] !== exp_d) begin
                errors++;
                $display("FAIL mid_data lane=%0d data=%0d expected %0d %0d", res_lane[0], res_data[0], i, exp_d);
            end
            @(negedge clk);
        end
        checks++; if (done[0] !== 1'b1) begin errors++; $display("FAIL mid_done got %b expected 1", done[0]); end
        @(negedge clk);
    endtask

    task automatic test_perf();
        int t = 0;
        logic [31:0] perf_exp;
`ifdef MATVEC_SEQ_PERF_EN
        perf_exp = 32'd31;
`else
        perf_exp = 32'd0;
`endif
        prep(0, 0, 8);
        pulse_start(0);
        do_load(0, 5);
        while (done[0] !== 1'b1 && t < 100) begin @(negedge clk); t++; end
        checks++; if (t >= 100) begin errors++; $display("FAIL perf_done_wait got 0 expected 1"); end
        @(negedge clk);
        checks++; if (perf_cycles[0] !== perf_exp) begin errors++; $display("FAIL perf_count got %0d expected %0d", perf_cycles[0], perf_exp); end
        repeat (4) @(negedge clk);
        checks++; if (perf_cycles[0] !== perf_exp) begin errors++; $display("FAIL perf_hold got %0d expected %0d", perf_cycles[0], perf_exp); end
    endtask

    initial begin
        rst       = 1'b1;
        start     = '0;
        load_done = '0;
        res_ready = 2'b11;
        prep(0, 0, 8);
        prep(1, 0, 8);
        @(negedge clk);
        test_reset();
        test_basic();
        test_backpressure();
        test_batch();
        test_underflow();
        test_reset_mid_exec();
        test_perf();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
